// File: rtl/add_sub_pkg.sv
// Shared types for the add_sub_acc unit: operation encoding and the status-flag bundle.
package add_sub_pkg;

  typedef enum logic [1:0] {
    OP_ADD      = 2'b00,
    OP_SUB      = 2'b01,
    OP_ACC_ADD  = 2'b10,
    OP_ACC_LOAD = 2'b11
  } op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/add_sub_core.sv
// Combinational N-bit adder/subtractor with carry/borrow, signed overflow, zero and negative flags.
// Optional signed saturation is compiled in when ADD_SUB_ACC_SAT_EN is defined.
module add_sub_core
  import add_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output flags_t       flags
);

  logic [N-1:0] b_eff_s;
  logic [N:0]   full_s;
  logic [N-1:0] raw_s;
  logic         ovf_s;

  // Subtraction is a + ~b + 1; overflow when both addends share a sign the raw result lacks.
  always_comb begin
    b_eff_s = sub ? ~b : b;
    full_s  = {1'b0, a} + {1'b0, b_eff_s} + {{N{1'b0}}, sub};
    raw_s   = full_s[N-1:0];
    ovf_s   = (a[N-1] == b_eff_s[N-1]) && (raw_s[N-1] != a[N-1]);
`ifdef ADD_SUB_ACC_SAT_EN
    if (ovf_s) begin
      sum = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      sum = raw_s;
    end
`else
    sum = raw_s;
`endif
    flags.carry    = sub ? ~full_s[N] : full_s[N];
    flags.overflow = ovf_s;
    flags.zero     = (sum == {N{1'b0}});
    flags.negative = sum[N-1];
  end

endmodule

// File: rtl/add_sub_acc.sv
// Handshaked add/subtract unit with accumulator; one output register, 1-cycle latency, full throughput.
// Build option: ADD_SUB_ACC_SAT_EN enables signed saturation inside add_sub_core.
module add_sub_acc
  import add_sub_pkg::*;
#(
  parameter int           N        = 8,
  parameter logic [N-1:0] ACC_INIT = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] x0,
  input  logic [N-1:0] x1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic [N-1:0] acc
);

  logic [N-1:0] core_a_s;
  logic [N-1:0] core_b_s;
  logic         core_sub_s;
  logic         acc_wr_s;
  logic [N-1:0] core_sum_s;
  flags_t       core_flags_s;

  logic         out_valid_r;
  logic [N-1:0] result_r;
  flags_t       flags_r;
  logic [N-1:0] acc_r;

  logic         in_xfer_s;
  logic         out_xfer_s;

  assign in_ready   = !out_valid_r || out_ready;
  assign in_xfer_s  = in_valid && in_ready;
  assign out_xfer_s = out_valid_r && out_ready;

  // Operand routing; ACC_LOAD passes x0 through the adder with b=0 so carry/overflow come out 0.
  always_comb begin
    core_a_s   = x0;
    core_b_s   = x1;
    core_sub_s = 1'b0;
    acc_wr_s   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        core_sub_s = 1'b0;
      end
      OP_SUB: begin
        core_sub_s = 1'b1;
      end
      OP_ACC_ADD: begin
        core_a_s = acc_r;
        core_b_s = x0;
        acc_wr_s = 1'b1;
      end
      OP_ACC_LOAD: begin
        core_b_s = {N{1'b0}};
        acc_wr_s = 1'b1;
      end
      default: begin
        core_sub_s = 1'b0;
      end
    endcase
  end

  add_sub_core #(.N(N)) u_core (
    .a     (core_a_s),
    .b     (core_b_s),
    .sub   (core_sub_s),
    .sum   (core_sum_s),
    .flags (core_flags_s)
  );

  // Output register and accumulator; a new input replaces the held result even on a same-cycle take.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= {N{1'b0}};
      flags_r     <= flags_t'(4'b0000);
      acc_r       <= ACC_INIT;
    end else if (in_xfer_s) begin
      out_valid_r <= 1'b1;
      result_r    <= core_sum_s;
      flags_r     <= core_flags_s;
      if (acc_wr_s) begin
        acc_r <= core_sum_s;
      end
    end else if (out_xfer_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign carry     = flags_r.carry;
  assign overflow  = flags_r.overflow;
  assign zero      = flags_r.zero;
  assign negative  = flags_r.negative;
  assign acc       = acc_r;

endmodule

// File: tb/tb_add_sub_acc.sv
// Self-checking bench for add_sub_acc: directed cases plus a random stream against an integer reference model.
module tb_add_sub_acc;

  localparam int           N        = 8;
  localparam logic [N-1:0] ACC_INIT = 8'h00;
`ifdef ADD_SUB_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] x0 = 8'h00;
  logic [N-1:0] x1 = 8'h00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic [N-1:0] acc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N+3:0] exp_q[$];
  logic [N-1:0] m_acc;

  add_sub_acc #(.N(N), .ACC_INIT(ACC_INIT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .x0(x0), .x1(x1), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero), .negative(negative), .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sg(input int u);
    return (u >= 2**(N-1)) ? u - 2**N : u;
  endfunction

  // Reference: packs {result, carry, overflow, zero, negative}; returns next accumulator value.
  function automatic logic [N+3:0] ref_op(input logic [1:0] o, input logic [N-1:0] a0,
                                         input logic [N-1:0] a1, input logic [N-1:0] av,
                                         output logic [N-1:0] nacc);
    int u, s, t;
    bit c, v;
    logic [N-1:0] r;
    case (o)
      2'd0: begin u = int'(a0) + int'(a1); c = (u >= 2**N); s = sg(int'(a0)) + sg(int'(a1)); end
      2'd1: begin u = int'(a0) - int'(a1); c = (a0 < a1);   s = sg(int'(a0)) - sg(int'(a1)); end
      2'd2: begin u = int'(av) + int'(a0); c = (u >= 2**N); s = sg(int'(av)) + sg(int'(a0)); end
      default: begin u = int'(a0); c = 1'b0; s = sg(int'(a0)); end
    endcase
    v = (s > 2**(N-1) - 1) || (s < -(2**(N-1)));
    r = u[N-1:0];
    if (SAT && v) begin
      t = (s > 0) ? 2**(N-1) - 1 : 2**(N-1);
      r = t[N-1:0];
    end
    nacc = (o == 2'd2 || o == 2'd3) ? r : av;
    return {r, c, v, (r == 8'h00), r[N-1]};
  endfunction

  task automatic cycle(input bit v, input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit ordy);
    bit ix, ox;
    logic [N-1:0] nacc;
    @(negedge clk);
    in_valid = v; op = o; x0 = a; x1 = b; out_ready = ordy;
    #1;
    check("out_valid", out_valid, exp_q.size() > 0);
    check("in_ready", in_ready, (exp_q.size() == 0) || ordy);
    check("acc", acc, m_acc);
    if (exp_q.size() > 0) check("result_flags", {result, carry, overflow, zero, negative}, exp_q[0]);
    ox = (exp_q.size() > 0) && ordy;
    ix = v && ((exp_q.size() == 0) || ordy);
    @(posedge clk);
    if (ox) void'(exp_q.pop_front());
    if (ix) begin
      exp_q.push_back(ref_op(o, a, b, m_acc, nacc));
      m_acc = nacc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; op = 2'd0; x0 = 8'h12; x1 = 8'h34; out_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_acc = ACC_INIT;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_flags", {carry, overflow, zero, negative}, 4'b0000);
    check("rst_acc", acc, ACC_INIT);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_add;
    m_acc = ACC_INIT;
    do_reset();

    exp_add = SAT ? 8'h7F : 8'h80;
    cycle(1'b1, 2'd0, 8'h7F, 8'h01, 1'b1);
    #1;
    check("add_7f_01", {result, carry, overflow, zero, negative}, {exp_add, 1'b0, 1'b1, 1'b0, ~SAT});
    cycle(1'b1, 2'd1, 8'h05, 8'h07, 1'b1);
    #1;
    check("sub_5_7", {result, carry, overflow, zero, negative}, {8'hFE, 4'b1001});
    cycle(1'b1, 2'd1, 8'h07, 8'h07, 1'b1);
    #1;
    check("sub_7_7", {result, carry, overflow, zero, negative}, {8'h00, 4'b0010});

    cycle(1'b1, 2'd3, 8'h10, 8'h99, 1'b1);
    cycle(1'b1, 2'd2, 8'h20, 8'h99, 1'b1);
    #1;
    check("acc_add_30", {result, carry}, {8'h30, 1'b0});
    cycle(1'b1, 2'd2, 8'hF0, 8'h99, 1'b1);
    #1;
    check("acc_add_wrap", {result, carry, acc}, {8'h20, 1'b1, 8'h20});
    cycle(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);

    // Stall: one transfer held for three cycles, then a same-cycle in/out transfer.
    cycle(1'b1, 2'd0, 8'h11, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd1, 8'h40, 8'h01, 1'b0);
    #1;
    check("stall_result", {out_valid, in_ready, result}, {1'b1, 1'b0, 8'h33});
    cycle(1'b1, 2'd1, 8'h40, 8'h01, 1'b1);
    #1;
    check("swap_result", {out_valid, result}, {1'b1, 8'h3F});
    cycle(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);

    // Reset while a result is pending and acc holds 0x55.
    cycle(1'b1, 2'd3, 8'h55, 8'h00, 1'b0);
    #1;
    check("pre_rst_acc", {out_valid, acc}, {1'b1, 8'h55});
    do_reset();

    for (int i = 0; i < 1000; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    check("drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
